// File: rtl/skid_buf_n.sv
// skid_buf_n: two-entry skid buffer between a valid/ready producer and consumer.
// The main register always drives m_data; the skid register catches the one
// word that can arrive on the cycle the downstream stalls. Every output is a
// flop, so there is no combinational path from s_valid, s_data or m_ready to
// any output and the buffer breaks timing in both directions.
module skid_buf_n #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_main;
  logic [N-1:0]   r_skid;
  logic           r_s_ready;
  logic           r_m_valid;
  logic [1:0]     r_level;

  logic           w_in_xfer;
  logic           w_out_xfer;

  // Transfers are qualified by the registered handshake outputs, so they
  // agree exactly with what the neighbours see on the ports.
  assign w_in_xfer  = s_valid & r_s_ready;
  assign w_out_xfer = m_valid & m_ready;

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_main;
  assign level   = r_level;

  // Occupancy FSM with registered outputs; each branch loads the handshake
  // flags and level for the state it moves to, and the unused encoding
  // falls back to EMPTY on the next edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_level   <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main    <= s_data;
            r_state   <= BUSY;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b1;
            r_level   <= 2'd1;
          end
        end
        BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            // Consumed word is replaced by the arriving one; occupancy unchanged.
            r_main <= s_data;
          end else if (w_in_xfer) begin
            // Downstream stalled: park the new word behind the head.
            r_skid    <= s_data;
            r_state   <= FULL;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b1;
            r_level   <= 2'd2;
          end else if (w_out_xfer) begin
            r_state   <= EMPTY;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_level   <= 2'd0;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            // Head leaves; the parked word moves up. s_ready was 0, so no input.
            r_main    <= r_skid;
            r_state   <= BUSY;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b1;
            r_level   <= 2'd1;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
          r_level   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buf_n.sv
// Testbench for skid_buf_n: directed vectors plus a long random-handshake run.
// The driver pushes each word into a scoreboard queue when it is accepted; an
// independent monitor pops and compares whenever the DUT completes an output
// transfer, and also checks the handshake/level invariants every cycle.
module tb_skid_buf_n;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [N-1:0] m_data;
  logic         m_ready;
  logic [1:0]   level;

  int n_vec;
  int n_err;
  logic [N-1:0] sb_q[$];

  skid_buf_n #(.N(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .level  (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive just after the rising edge, then at the
  // falling edge record the word in the scoreboard if it will be accepted.
  task automatic step(input logic v, input logic [N-1:0] d, input logic mr,
                      output logic acc);
    @(posedge clock);
    #1;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    @(negedge clock);
    acc = s_valid && s_ready;
    if (acc) sb_q.push_back(s_data);
  endtask

  // Monitor: pop/compare on output transfers and check per-cycle invariants.
  logic         prev_hold;
  logic [N-1:0] prev_data;
  initial begin
    logic [N-1:0] exp_w;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_hold = 1'b0;
      end else begin
        chk("s_ready_vs_level", int'(s_ready), int'(level != 2'd2));
        chk("m_valid_vs_level", int'(m_valid), int'(level != 2'd0));
        if (prev_hold) begin
          chk("stall_valid", int'(m_valid), 1);
          chk("stall_data", int'(m_data), int'(prev_data));
        end
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            exp_w = sb_q.pop_front();
            chk("out_data", int'(m_data), int'(exp_w));
          end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  initial begin
    logic acc;
    logic hold;
    logic v;
    logic [N-1:0] d;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Reset values.
    #12;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_level", int'(level), 0);
    @(negedge clock);
    reset = 1'b1;

    // One word into EMPTY, one-cycle latency.
    step(1'b1, 8'hA5, 1'b0, acc);
    chk("a5_accept", int'(acc), 1);
    chk("a5_pre_valid", int'(m_valid), 0);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("a5_valid", int'(m_valid), 1);
    chk("a5_data", int'(m_data), 8'hA5);
    chk("a5_level", int'(level), 1);

    // Simultaneous in/out in BUSY: head replaced, level stays 1.
    step(1'b1, 8'h44, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("swap_data", int'(m_data), 8'h44);
    chk("swap_level", int'(level), 1);
    step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("drain1_level", int'(level), 0);

    // Fill to FULL, offer a word that must be refused, then pop one.
    step(1'b1, 8'h01, 1'b0, acc);
    step(1'b1, 8'h02, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("full_level", int'(level), 2);
    chk("full_s_ready", int'(s_ready), 0);
    chk("full_data", int'(m_data), 8'h01);
    step(1'b1, 8'hEE, 1'b0, acc);
    chk("full_refuse", int'(acc), 0);
    step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("unfull_data", int'(m_data), 8'h02);
    chk("unfull_level", int'(level), 1);
    chk("unfull_s_ready", int'(s_ready), 1);
    step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("drain2_level", int'(level), 0);

    // Full-rate stream 0x00..0xFF with m_ready held high.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i), 1'b1, acc);
      if (i >= 1) chk("stream_level", int'(level), 1);
    end
    step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("stream_drained", sb_q.size(), 0);
    chk("stream_end_level", int'(level), 0);

    // Reset while FULL discards both words immediately.
    step(1'b1, 8'h11, 1'b0, acc);
    step(1'b1, 8'h22, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("prerst_level", int'(level), 2);
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_m_data", int'(m_data), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    @(negedge clock);
    reset = 1'b1;

    // First edge after release accepts; nothing replayed.
    step(1'b1, 8'h5A, 1'b0, acc);
    chk("postrst_accept", int'(acc), 1);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("postrst_data", int'(m_data), 8'h5A);
    chk("postrst_level", int'(level), 1);
    step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);

    // Random handshakes; an offered word is held until accepted.
    hold = 1'b0;
    v = 1'b0;
    d = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      step(v, d, 1'($urandom_range(0, 1)), acc);
      hold = v && !acc;
    end
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("rand_drained", sb_q.size(), 0);
    chk("rand_end_level", int'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
